dp_ram_arbiter: RTL and testbench

Shares one simple dual-port block RAM (`dp_ram`: write port A, registered read port B) between two write requesters and two read requesters. Port A and port B are each arbitrated round-robin. Reads return tagged with the requester ID one cycle after grant. A read that collides with a same-cycle write to the same address is stalled one cycle so that it returns the new data. The block sits between the accelerator's loader/writeback engines and each on-chip buffer instance.

---
 rtl/dp_ram_arbiter.sv | 107 ++++++++++
 tb/tb_dp_ram_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_arbiter.sv
// dp_ram_arbiter: round-robin sharing of one simple dual-port RAM between two
// writers (port A) and two readers (port B). Read responses are tagged with
// the requester ID one cycle after grant. A read whose address matches the
// same-cycle granted write is held off one cycle so it sees the new data.
module dp_ram_arbiter #(
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_req,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_gnt,
  input  logic                  wr1_req,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_gnt,
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_gnt,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_gnt,
  output logic                  rd_dvalid,
  output logic                  rd_did,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           coll_cnt,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic        rd_dvalid_q, rd_dvalid_d;
  logic        rd_did_q, rd_did_d;
  logic [15:0] coll_cnt_q, coll_cnt_d;

  logic                  w_any, w_sel;
  logic                  r_any, r_sel, r_coll, r_gnt;
  logic [ADDR_WIDTH-1:0] r_cand_addr;

  // Stall counter stops at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Arbitrate both ports, detect read-after-write collisions, drive the RAM.
  always_comb begin
    w_any       = wr0_req | wr1_req;
    // Sole requester wins; on contention the priority pointer decides.
    w_sel       = (wr0_req & wr1_req) ? wptr_q : wr1_req;
    r_any       = rd0_req | rd1_req;
    r_sel       = (rd0_req & rd1_req) ? rptr_q : rd1_req;
    r_cand_addr = r_sel ? rd1_addr : rd0_addr;

    ram_ena   = w_any;
    ram_wea   = w_any;
    ram_addra = w_sel ? wr1_addr : wr0_addr;
    ram_dia   = w_sel ? wr1_data : wr0_data;
    wr0_gnt   = w_any & ~w_sel;
    wr1_gnt   = w_any & w_sel;

    // The candidate is stalled, not swapped for the other reader.
    r_coll    = w_any & r_any & (r_cand_addr == ram_addra);
    r_gnt     = r_any & ~r_coll;
    ram_enb   = r_gnt;
    ram_addrb = r_cand_addr;
    rd0_gnt   = r_gnt & ~r_sel;
    rd1_gnt   = r_gnt & r_sel;

    wptr_d      = w_any ? ~w_sel : wptr_q;
    rptr_d      = r_gnt ? ~r_sel : rptr_q;
    rd_dvalid_d = r_gnt;
    rd_did_d    = r_gnt ? r_sel : rd_did_q;
    coll_cnt_d  = r_coll ? sat_inc(coll_cnt_q) : coll_cnt_q;
  end

  // Control state; reset drops any in-flight response but leaves the RAM alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      rd_dvalid_q <= 1'b0;
      rd_did_q    <= 1'b0;
      coll_cnt_q  <= 16'd0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_dvalid_q <= rd_dvalid_d;
      rd_did_q    <= rd_did_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign rd_dvalid = rd_dvalid_q;
  assign rd_did    = rd_did_q;
  assign coll_cnt  = coll_cnt_q;
  assign rd_data   = ram_dob;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model with a shadow memory.
module tb_dp_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr0_req, wr1_req, rd0_req, rd1_req;
  logic [3:0]  wr0_addr, wr1_addr, rd0_addr, rd1_addr;
  logic [63:0] wr0_data, wr1_data;
  logic        wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt;
  logic        rd_dvalid, rd_did;
  logic [63:0] rd_data;
  logic [15:0] coll_cnt;
  logic        ram_ena, ram_wea, ram_enb;
  logic [3:0]  ram_addra, ram_addrb;
  logic [63:0] ram_dia;
  logic [63:0] ram_dob = 64'd0;
  logic [63:0] ram_mem [16] = '{default: 64'd0};

  int tests = 0;
  int fails = 0;

  // Reference state
  int          m_wptr, m_rptr, m_dv, m_did, m_coll;
  logic [63:0] m_mem [16] = '{default: 64'd0};
  logic [63:0] m_data;
  bit          e_wg0, e_wg1, e_rg0, e_rg1;

  always #5 clk = ~clk;

  // Behavioural RAM: write on port A, registered read on port B.
  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= ram_mem[ram_addrb];
  end

  dp_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd_dvalid(rd_dvalid), .rd_did(rd_did), .rd_data(rd_data), .coll_cnt(coll_cnt),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
  endtask

  // One clock: inputs already applied after a falling edge.
  task automatic cycle();
    int wk, rc, waddr, raddr;
    bit w_any, r_any, coll, rg;
    logic [63:0] wdata;
    #1;
    w_any = wr0_req || wr1_req;
    wk    = (wr0_req && wr1_req) ? m_wptr : (wr1_req ? 1 : 0);
    waddr = (wk == 1) ? int'(wr1_addr) : int'(wr0_addr);
    wdata = (wk == 1) ? wr1_data : wr0_data;
    r_any = rd0_req || rd1_req;
    rc    = (rd0_req && rd1_req) ? m_rptr : (rd1_req ? 1 : 0);
    raddr = (rc == 1) ? int'(rd1_addr) : int'(rd0_addr);
    coll  = w_any && r_any && (raddr == waddr);
    rg    = r_any && !coll;
    e_wg0 = w_any && wk == 0; e_wg1 = w_any && wk == 1;
    e_rg0 = rg && rc == 0;    e_rg1 = rg && rc == 1;
    chk("wr0_gnt", wr0_gnt, e_wg0);
    chk("wr1_gnt", wr1_gnt, e_wg1);
    chk("rd0_gnt", rd0_gnt, e_rg0);
    chk("rd1_gnt", rd1_gnt, e_rg1);
    chk("ram_ena", ram_ena, w_any);
    chk("ram_wea", ram_wea, w_any);
    chk("ram_enb", ram_enb, rg);
    if (w_any) begin
      chk("ram_addra", ram_addra, waddr);
      chk("ram_dia", ram_dia, wdata);
    end
    if (rg) chk("ram_addrb", ram_addrb, raddr);
    if (rg) m_data = m_mem[raddr];
    if (w_any) m_mem[waddr] = wdata;
    if (rst) begin
      m_wptr = 0; m_rptr = 0; m_dv = 0; m_did = 0; m_coll = 0;
    end else begin
      if (w_any) m_wptr = 1 - wk;
      if (rg) begin m_rptr = 1 - rc; m_did = rc; end
      m_dv = rg ? 1 : 0;
      if (coll && m_coll < 65535) m_coll++;
    end
    @(posedge clk); #1;
    chk("rd_dvalid", rd_dvalid, m_dv);
    chk("rd_did", rd_did, m_did);
    chk("coll_cnt", coll_cnt, m_coll);
    if (m_dv == 1) chk("rd_data", rd_data, m_data);
    @(negedge clk);
  endtask

  initial begin
    idle();
    wr0_addr = 0; wr1_addr = 0; rd0_addr = 0; rd1_addr = 0;
    wr0_data = 0; wr1_data = 0;
    m_wptr = 0; m_rptr = 0; m_dv = 0; m_did = 0; m_coll = 0; m_data = 0;
    rst = 1;
    @(negedge clk);
    cycle(); cycle();
    chk("reset_dvalid", rd_dvalid, 0);
    chk("reset_did", rd_did, 0);
    chk("reset_coll", coll_cnt, 0);
    rst = 0;

    // Single write then read
    wr0_req = 1; wr0_addr = 3; wr0_data = 64'hDEAD;
    cycle();
    idle(); rd1_req = 1; rd1_addr = 3;
    cycle();
    chk("t1_dvalid", rd_dvalid, 1);
    chk("t1_did", rd_did, 1);
    chk("t1_data", rd_data, 64'hDEAD);
    idle(); cycle();

    // Write contention: alternating grants starting from writer 0
    rst = 1; cycle(); rst = 0;
    wr0_req = 1; wr0_addr = 1; wr0_data = 64'hA;
    wr1_req = 1; wr1_addr = 2; wr1_data = 64'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wcont_g0", wr0_gnt, (i % 2 == 0) ? 1 : 0);
      chk("wcont_g1", wr1_gnt, (i % 2 == 1) ? 1 : 0);
      cycle();
    end
    idle(); rd0_req = 1; rd0_addr = 1; cycle();
    chk("wcont_rd_a", rd_data, 64'hA);
    rd0_addr = 2; cycle();
    chk("wcont_rd_b", rd_data, 64'hB);
    idle(); cycle();

    // Read contention: rd_did 0,1,0,1,0,1
    rst = 1; cycle(); rst = 0;
    rd0_req = 1; rd0_addr = 1; rd1_req = 1; rd1_addr = 2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rcont_did", rd_did, i % 2);
      chk("rcont_dv", rd_dvalid, 1);
    end
    idle(); cycle();

    // Collision: read of addr 5 stalled behind write, returns new data
    rst = 1; cycle(); rst = 0;
    wr0_req = 1; wr0_addr = 5; wr0_data = 64'h1; cycle();
    wr0_data = 64'h2; rd0_req = 1; rd0_addr = 5;
    #1; chk("coll_stall_gnt", rd0_gnt, 0);
    cycle();
    wr0_req = 0;
    #1; chk("coll_retry_gnt", rd0_gnt, 1);
    cycle();
    idle();
    chk("coll_data", rd_data, 64'h2);
    chk("coll_cnt_one", coll_cnt, 1);
    cycle();

    // Independent write and read in the same cycle
    wr1_req = 1; wr1_addr = 7; wr1_data = 64'h77; rd1_req = 1; rd1_addr = 8;
    #1; chk("indep_wg", wr1_gnt, 1); chk("indep_rg", rd1_gnt, 1);
    cycle();
    chk("indep_coll", coll_cnt, 1);
    idle(); cycle();

    // Reset while a read is granted: response discarded, pointers back to 0
    rd0_req = 1; rd0_addr = 7; rd1_req = 1; rd1_addr = 8; cycle();
    rd1_req = 0; rst = 1; cycle();
    rst = 0;
    chk("rst_mid_dv", rd_dvalid, 0);
    chk("rst_mid_coll", coll_cnt, 0);
    rd0_req = 1; rd1_req = 1;
    #1; chk("rst_ptr_r0", rd0_gnt, 1);
    cycle();
    idle(); wr0_req = 1; wr1_req = 1; wr0_addr = 9; wr1_addr = 10;
    #1; chk("rst_ptr_w0", wr0_gnt, 1);
    cycle();
    idle(); cycle();

    // Randomized traffic with small address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      if (!wr0_req || e_wg0) begin
        wr0_req = 1'($urandom_range(0, 1)); wr0_addr = 4'($urandom_range(0, 3));
        wr0_data = {$urandom, $urandom};
      end
      if (!wr1_req || e_wg1) begin
        wr1_req = 1'($urandom_range(0, 1)); wr1_addr = 4'($urandom_range(0, 3));
        wr1_data = {$urandom, $urandom};
      end
      if (!rd0_req || e_rg0) begin
        rd0_req = 1'($urandom_range(0, 1)); rd0_addr = 4'($urandom_range(0, 3));
      end
      if (!rd1_req || e_rg1) begin
        rd1_req = 1'($urandom_range(0, 1)); rd1_addr = 4'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 0; idle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
